// File: rtl/axi_reg_slice_fifo_pkg.sv
// Shared definitions for the valid/ready register slice family: pointer wrap
// helper, level type and build-time mode constants.
package axi_rs_pkg;

  localparam int unsigned RS_MAX_DEPTH = 16;
  localparam int unsigned RS_PTR_W     = 4;
  localparam int unsigned RS_LVL_W     = 5;

  // Build-time selection between a removed stage and a buffered stage.
  localparam bit RS_PASS = 1'b1;
  localparam bit RS_BUF  = 1'b0;

  typedef logic [RS_PTR_W-1:0] rs_ptr_t;
  typedef logic [RS_LVL_W-1:0] rs_level_t;

  // Advance a circular pointer, wrapping depth-1 -> 0 (depth need not be 2^n).
  function automatic rs_ptr_t ptr_inc(input rs_ptr_t ptr, input rs_level_t depth);
    rs_ptr_t last;
    last = rs_ptr_t'(depth - 5'd1);
    if (ptr == last) begin
      return {RS_PTR_W{1'b0}};
    end else begin
      return ptr + 4'd1;
    end
  endfunction

endpackage

// File: rtl/axi_reg_slice_fifo.sv
// Single-channel valid/ready register slice with DEPTH-entry circular storage,
// occupancy output and almost-full flag. PASS=1 removes the stage entirely.
module axi_reg_slice_fifo
  import axi_rs_pkg::*;
#(
  parameter int unsigned PLD_W  = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AF_LVL = DEPTH - 1,
  parameter bit          PASS   = RS_BUF,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [PLD_W-1:0] payload_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [PLD_W-1:0] payload_o,
  output logic [LVL_W-1:0] level_o,
  output logic             afull_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(AF_LVL);

  if (PASS == RS_PASS) begin : g_pass
    // Stage removed: wires only, clock and reset are intentionally unused.
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = ^{aclk, areset};
    assign valid_o   = valid_i;
    assign ready_o   = ready_i;
    assign payload_o = payload_i;
    assign level_o   = LVL_ZERO;
    assign afull_o   = 1'b0;
  end else begin : g_buf
    logic [PLD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             valid_q, ready_q, afull_q;
    logic             push_s, pop_s;

    // Handshakes, pointer advance and next occupancy.
    always_comb begin
      push_s   = valid_i & ready_q;
      pop_s    = valid_q & ready_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
        wr_ptr_d = PTR_W'(ptr_inc(RS_PTR_W'(wr_ptr_q), RS_LVL_W'(DEPTH)));
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = PTR_W'(ptr_inc(RS_PTR_W'(rd_ptr_q), RS_LVL_W'(DEPTH)));
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + LVL_ONE;
        2'b01:   count_d = count_q - LVL_ONE;
        default: count_d = count_q;
      endcase
    end

    // Storage write, pointers, counter and registered handshake/status flags.
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        wr_ptr_q <= {PTR_W{1'b0}};
        rd_ptr_q <= {PTR_W{1'b0}};
        count_q  <= LVL_ZERO;
        valid_q  <= 1'b0;
        ready_q  <= 1'b0;
        afull_q  <= 1'b0;
      end else begin
        if (push_s) begin
          mem_q[wr_ptr_q] <= payload_i;
        end
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        valid_q  <= (count_d != LVL_ZERO);
        ready_q  <= (count_d != LVL_FULL);
        afull_q  <= (count_d >= LVL_AF);
      end
    end

    assign valid_o   = valid_q;
    assign ready_o   = ready_q;
    assign payload_o = mem_q[rd_ptr_q];
    assign level_o   = count_q;
    assign afull_o   = afull_q;
  end

endmodule
